// File: rtl/ads_router_pkg.sv
// Shared constants, FSM state type and sample helpers for the ADS1299 frame router.
package ads_router_pkg;

   localparam int N_CH     = 8;
   localparam int SAMPLE_W = 24;
   localparam int WORD_W   = 32;
   localparam int FRAME_W  = N_CH * SAMPLE_W;
   localparam int CH_IDX_W = 3;

   localparam logic [7:0] HDR_TAG = 8'hA5;

   // Raw-stream sequencer states: header word first, then the eight channel words.
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SEND_HDR = 2'd1,
      ST_SEND_CH  = 2'd2
   } state_e;

   // Two's-complement 24-bit sample widened to a 32-bit stream word.
   function automatic logic [WORD_W-1:0] sign_extend(input logic [SAMPLE_W-1:0] s);
      return {{(WORD_W - SAMPLE_W){s[SAMPLE_W-1]}}, s};
   endfunction

   // Pick channel idx out of a packed frame (ch0 in the low bits).
   function automatic logic [SAMPLE_W-1:0] get_sample(input logic [FRAME_W-1:0] f,
                                                      input logic [CH_IDX_W-1:0] idx);
      return f[32'(idx) * SAMPLE_W +: SAMPLE_W];
   endfunction

endpackage

// File: rtl/st_hold_reg.sv
// One-word Avalon-ST hold register: a load pulse captures a word and raises valid,
// which then stays up (data frozen) until the sink accepts it with ready.
module st_hold_reg
   import ads_router_pkg::*;
#(
   parameter int W = WORD_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_data,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   input  logic         out_ready
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   // Load wins; otherwise a handshake retires the held word.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   // State register with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;

endmodule

// File: rtl/ads_frame_router.sv
// ADS1299 frame router: streams each accepted frame as a 9-word raw packet and
// copies four selectable channels into independent single-word tap outputs.
//
// Handshake rule for every source here: a word transfers on a rising edge where
// valid and ready are both high; once valid is raised, valid and data hold
// unchanged until that transfer, and ready never feeds back into valid.
module ads_frame_router
   import ads_router_pkg::*;
#(
   parameter int unsigned SEL1 = 0,
   parameter int unsigned SEL2 = 1,
   parameter int unsigned SEL3 = 2,
   parameter int unsigned SEL4 = 3
) (
   input  logic          clk_clk,
   input  logic          reset_reset_n,
   input  logic          enable,
   input  logic          frame_valid,
   input  logic [23:0]   frame_status,
   input  logic [191:0]  frame_data,
   output logic          raw_out_valid,
   output logic [31:0]   raw_out_data,
   input  logic          raw_out_ready,
   output logic          fifo_1_out_valid,
   output logic [31:0]   fifo_1_out_data,
   input  logic          fifo_1_out_ready,
   output logic          fifo_2_out_valid,
   output logic [31:0]   fifo_2_out_data,
   input  logic          fifo_2_out_ready,
   output logic          fifo_3_out_valid,
   output logic [31:0]   fifo_3_out_data,
   input  logic          fifo_3_out_ready,
   output logic          fifo_4_out_valid,
   output logic [31:0]   fifo_4_out_data,
   input  logic          fifo_4_out_ready,
   output logic          busy,
   output logic [15:0]   drop_count
);

   state_e                state_q, state_d;
   logic [CH_IDX_W-1:0]   ch_idx_q, ch_idx_d;
   logic [FRAME_W-1:0]    frame_q, frame_d;
   logic                  raw_valid_q, raw_valid_d;
   logic [WORD_W-1:0]     raw_data_q, raw_data_d;
   logic [15:0]           drop_q, drop_d;

   logic                  accept;
   logic                  raw_hs;
   logic                  taps_busy;

   // A new frame needs the sequencer idle and every tap already drained, so no
   // tap word from the previous frame is ever overwritten.
   assign taps_busy = fifo_1_out_valid | fifo_2_out_valid | fifo_3_out_valid | fifo_4_out_valid;
   assign accept    = frame_valid && enable && (state_q == ST_IDLE) && !taps_busy;
   assign raw_hs    = raw_valid_q && raw_out_ready;

   // Next-state, raw-word and drop-counter logic.
   always_comb begin
      state_d     = state_q;
      ch_idx_d    = ch_idx_q;
      frame_d     = frame_q;
      raw_valid_d = raw_valid_q;
      raw_data_d  = raw_data_q;
      drop_d      = drop_q;

      // Enabled frames that cannot be taken are lost; count them, sticking at max.
      if (frame_valid && enable && !accept && (drop_q != 16'hFFFF)) begin
         drop_d = drop_q + 16'd1;
      end

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               frame_d     = frame_data;
               raw_valid_d = 1'b1;
               raw_data_d  = {HDR_TAG, frame_status};
               state_d     = ST_SEND_HDR;
            end
         end
         ST_SEND_HDR: begin
            if (raw_hs) begin
               ch_idx_d   = '0;
               raw_data_d = sign_extend(get_sample(frame_q, '0));
               state_d    = ST_SEND_CH;
            end
         end
         ST_SEND_CH: begin
            if (raw_hs) begin
               if (ch_idx_q == CH_IDX_W'(N_CH - 1)) begin
                  raw_valid_d = 1'b0;
                  state_d     = ST_IDLE;
               end else begin
                  ch_idx_d   = ch_idx_q + 1'b1;
                  raw_data_d = sign_extend(get_sample(frame_q, ch_idx_q + 1'b1));
               end
            end
         end
         default: begin
            raw_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // Sequencer registers; reset discards any frame in flight.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q     <= ST_IDLE;
         ch_idx_q    <= '0;
         frame_q     <= '0;
         raw_valid_q <= 1'b0;
         raw_data_q  <= '0;
         drop_q      <= '0;
      end else begin
         state_q     <= state_d;
         ch_idx_q    <= ch_idx_d;
         frame_q     <= frame_d;
         raw_valid_q <= raw_valid_d;
         raw_data_q  <= raw_data_d;
         drop_q      <= drop_d;
      end
   end

   assign raw_out_valid = raw_valid_q;
   assign raw_out_data  = raw_data_q;
   assign busy          = (state_q != ST_IDLE);
   assign drop_count    = drop_q;

   // Taps load straight from the input frame on the accept edge.
   st_hold_reg #(.W(WORD_W)) u_tap1 (
      .clk       (clk_clk),
      .rst_n     (reset_reset_n),
      .load      (accept),
      .load_data (sign_extend(frame_data[SEL1*SAMPLE_W +: SAMPLE_W])),
      .out_valid (fifo_1_out_valid),
      .out_data  (fifo_1_out_data),
      .out_ready (fifo_1_out_ready)
   );

   st_hold_reg #(.W(WORD_W)) u_tap2 (
      .clk       (clk_clk),
      .rst_n     (reset_reset_n),
      .load      (accept),
      .load_data (sign_extend(frame_data[SEL2*SAMPLE_W +: SAMPLE_W])),
      .out_valid (fifo_2_out_valid),
      .out_data  (fifo_2_out_data),
      .out_ready (fifo_2_out_ready)
   );

   st_hold_reg #(.W(WORD_W)) u_tap3 (
      .clk       (clk_clk),
      .rst_n     (reset_reset_n),
      .load      (accept),
      .load_data (sign_extend(frame_data[SEL3*SAMPLE_W +: SAMPLE_W])),
      .out_valid (fifo_3_out_valid),
      .out_data  (fifo_3_out_data),
      .out_ready (fifo_3_out_ready)
   );

   st_hold_reg #(.W(WORD_W)) u_tap4 (
      .clk       (clk_clk),
      .rst_n     (reset_reset_n),
      .load      (accept),
      .load_data (sign_extend(frame_data[SEL4*SAMPLE_W +: SAMPLE_W])),
      .out_valid (fifo_4_out_valid),
      .out_data  (fifo_4_out_data),
      .out_ready (fifo_4_out_ready)
   );

endmodule

// File: doc/ads_frame_router.md
ADS_FRAME_ROUTER -- requirements
Module: ads_frame_router

Interface
REQ-001 The block SHALL have parameters: SEL1, 0, channel index (0..7) copied to fifo_1_out; SEL2, 1, same for fifo_2_out; SEL3, 2, same for fifo_3_out; SEL4, 3, same for fifo_4_out.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
clk_clk  in  1  sole clock, all logic rising-edge
reset_reset_n  in  1  asynchronous active-low reset
enable  in  1  high = accept new frames
frame_valid  in  1  one-cycle pulse, frame present
frame_status  in  24  ADS1299 status word
frame_data  in  192  8 x 24-bit two's-complement samples, ch0 at [23:0], ch7 at [191:168]
raw_out_valid  out  1  Avalon-ST source valid, full-frame stream
raw_out_data  out  32  header/sample word
raw_out_ready  in  1  sink ready
fifo_k_out_valid  out  1  tap k source valid (k = 1..4)
fifo_k_out_data  out  32  sign-extended channel SELk
fifo_k_out_ready  in  1  tap k sink ready
busy  out  1  high when state != IDLE
drop_count  out  16  frames lost, saturating

Function
REQ-003 Frame acceptance SHALL occur on a cycle with frame_valid=1, enable=1, state IDLE and all four fifo_k_out_valid=0; frame contents latched that edge.
REQ-004 frame_valid=1 with enable=1 but acceptance blocked (REQ-003) SHALL increment drop_count by 1, saturating at 0xFFFF; frame_valid with enable=0 SHALL be ignored and not counted.
REQ-005 FSM states SHALL be IDLE, SEND_HDR, SEND_CH; IDLE->SEND_HDR on acceptance; SEND_HDR->SEND_CH on raw handshake; SEND_CH stays while channel index < 7, ->IDLE on handshake of ch7.
REQ-006 Raw stream SHALL emit 9 words per frame: {8'hA5, frame_status}, then ch0..ch7 each sign-extended 24->32 bits.
REQ-007 raw_out_valid SHALL rise the cycle after acceptance (latency 1) and remain high until the ch7 handshake.
REQ-008 raw_out_data SHALL be stable while raw_out_valid=1 and raw_out_ready=0; one word per cycle when ready held high (frame drains in 9 cycles).
REQ-009 On acceptance each tap k SHALL load sign-extended channel SELk and set fifo_k_out_valid the next cycle, clearing it on its own handshake, independent of other taps and the raw stream.
REQ-010 frame_valid on the same cycle as the ch7 handshake SHALL be dropped and counted (state not yet IDLE).
REQ-011 enable deasserted mid-frame SHALL NOT abort the frame in progress or pending taps.
REQ-012 busy SHALL equal (state != IDLE).
REQ-013 Sign extension SHALL replicate bit 23 into bits 31:24; 24'h800000 -> 32'hFF800000, 24'h7FFFFF -> 32'h007FFFFF.

Reset
REQ-014 Reset assertion SHALL immediately force state IDLE, raw_out_valid=0, all fifo_k_out_valid=0, busy=0, drop_count=0, data outputs 0, asynchronously, including mid-frame.
REQ-015 After deassertion the first acceptable frame_valid SHALL be accepted normally; no partial frame from before reset SHALL be emitted.

Structure
REQ-016 Package ads_router_pkg SHALL hold N_CH=8, SAMPLE_W=24, WORD_W=32, HDR_TAG=8'hA5, the FSM state enum and the sign-extend function.
REQ-017 Each tap SHALL be an instance of sub-module st_hold_reg (load, 32-bit data, valid/ready hold register), instantiated four times.

Verification
REQ-018 Reset, one frame (status 24'hC00000, chN = N+1), ready high -> raw words A5C00000, 00000001..00000008 on 9 consecutive cycles from acceptance+1; taps 1..4 = 1,2,3,4; busy low after.
REQ-019 Same frame, raw_out_ready toggled 1/0 each cycle -> 9 words in order, data stable during stalls, drop_count=0.
REQ-020 Second frame_valid 3 cycles after first, and another on ch7-handshake cycle -> both dropped, drop_count=2, first frame intact.
REQ-021 fifo_2_out_ready held low, taps 1,3,4 drained, new frame offered -> dropped, drop_count+1; after fifo_2 handshake next frame accepted.
REQ-022 ch0 = 24'h800000 and ch1 = 24'h7FFFFF -> raw words FF800000, 007FFFFF; reset asserted at word 4 -> all valids 0 immediately, drop_count 0.
